avs_burst_mem_responder: RTL and testbench

Synthesizable Avalon-MM burst slave with on-chip 16-bit memory, serving as the responder for the Avalon-MM initiator side of the HyperRAM system. It accepts the same signal set the converter exposes (32-bit address, 16-bit data, 11-bit burstcount, waitrequest, readdatavalid). It stands in for the converter plus HyperRAM when exercising the driver/monitor in isolation, and serves as a golden-reference memory in system benches. It supports one outstanding burst, a fixed programmable read latency, and a sticky protocol-error flag.

---
 rtl/avs_burst_mem_responder.sv | 137 +++++++++++++
 tb/tb_avs_burst_mem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avs_burst_mem_responder.sv
// Avalon-MM burst slave backed by on-chip 16-bit memory.
// One outstanding burst, fixed read latency, sticky protocol-error flag.
module avs_burst_mem_responder #(
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    input  logic [10:0] avs_burstcount,
    output logic        avs_waitrequest,
    output logic [15:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_LAT,
        RD_BURST
    } state_t;

    state_t state, state_n;

    logic [DEPTH_LOG2-1:0] ptr, ptr_n, addr, waddr;
    logic [10:0]           remaining, rem_n, bc_eff;
    logic [3:0]            lat, lat_n;
    logic [15:0]           rdata_n;
    logic                  wait_n, rdv_n, err_n, we, beat;
    logic [15:0]           mem [DEPTH];
    logic                  unused_addr;

    assign addr        = avs_address[DEPTH_LOG2-1:0];
    assign unused_addr = ^avs_address[31:DEPTH_LOG2];
    assign bc_eff      = (avs_burstcount == 11'd0) ? 11'd1 : avs_burstcount;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        rem_n   = remaining;
        lat_n   = lat;
        wait_n  = avs_waitrequest;
        rdv_n   = 1'b0;
        rdata_n = avs_readdata;
        err_n   = err;
        we      = 1'b0;
        waddr   = ptr;
        beat    = 1'b0;

        case (state)
            IDLE: begin
                wait_n = 1'b0;
                if (!avs_waitrequest) begin
                    if (avs_write) begin
                        we    = 1'b1;
                        waddr = addr;
                        if (bc_eff > 11'd1) begin
                            ptr_n   = addr + 1'b1;
                            rem_n   = bc_eff - 11'd1;
                            state_n = WR_BURST;
                        end
                        if (avs_read) err_n = 1'b1;
                    end else if (avs_read) begin
                        ptr_n   = addr;
                        rem_n   = bc_eff;
                        lat_n   = 4'(READ_LATENCY - 1);
                        wait_n  = 1'b1;
                        state_n = RD_LAT;
                    end
                end
            end
            WR_BURST: begin
                if (avs_write) begin
                    we    = 1'b1;
                    ptr_n = ptr + 1'b1;
                    rem_n = remaining - 11'd1;
                    if (remaining == 11'd1) state_n = IDLE;
                end
                if (avs_read) err_n = 1'b1;
            end
            RD_LAT: begin
                // the last latency cycle already launches the first beat
                if (lat == 4'd0) beat = 1'b1;
                else             lat_n = lat - 4'd1;
            end
            RD_BURST: beat = 1'b1;
            default: state_n = IDLE;
        endcase

        if (beat) begin
            rdata_n = mem[ptr];
            rdv_n   = 1'b1;
            ptr_n   = ptr + 1'b1;
            rem_n   = remaining - 11'd1;
            if (remaining == 11'd1) begin
                state_n = IDLE;
                wait_n  = 1'b0;
            end else begin
                state_n = RD_BURST;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            ptr               <= '0;
            remaining         <= '0;
            lat               <= '0;
            avs_waitrequest   <= 1'b1;
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= 16'h0000;
            err               <= 1'b0;
        end else begin
            state             <= state_n;
            ptr               <= ptr_n;
            remaining         <= rem_n;
            lat               <= lat_n;
            avs_waitrequest   <= wait_n;
            avs_readdatavalid <= rdv_n;
            avs_readdata      <= rdata_n;
            err               <= err_n;
        end
    end

    // contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= avs_writedata;
    end

endmodule

// File: tb/tb_avs_burst_mem_responder.sv
// Scoreboard bench for avs_burst_mem_responder.
// Three instances cover read latencies 1, 2 and 15; sel picks the active one.
module tb_avs_burst_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [15:0] avs_writedata = '0;
    logic [10:0] avs_burstcount = '0;
    int          sel = 1;

    logic        wr_q [3];
    logic [15:0] rd_d [3];
    logic        rdv  [3];
    logic        er   [3];

    logic        wr_m, rdv_m, err_m;
    logic [15:0] rd_m;

    always #5 clk = ~clk;

    avs_burst_mem_responder #(.DEPTH_LOG2(10), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .avs_address(avs_address),
        .avs_read(avs_read && sel == 0), .avs_write(avs_write && sel == 0),
        .avs_writedata(avs_writedata), .avs_burstcount(avs_burstcount),
        .avs_waitrequest(wr_q[0]), .avs_readdata(rd_d[0]),
        .avs_readdatavalid(rdv[0]), .err(er[0]));

    avs_burst_mem_responder #(.DEPTH_LOG2(10), .READ_LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .avs_address(avs_address),
        .avs_read(avs_read && sel == 1), .avs_write(avs_write && sel == 1),
        .avs_writedata(avs_writedata), .avs_burstcount(avs_burstcount),
        .avs_waitrequest(wr_q[1]), .avs_readdata(rd_d[1]),
        .avs_readdatavalid(rdv[1]), .err(er[1]));

    avs_burst_mem_responder #(.DEPTH_LOG2(10), .READ_LATENCY(15)) u_l15 (
        .clk(clk), .rst(rst), .avs_address(avs_address),
        .avs_read(avs_read && sel == 2), .avs_write(avs_write && sel == 2),
        .avs_writedata(avs_writedata), .avs_burstcount(avs_burstcount),
        .avs_waitrequest(wr_q[2]), .avs_readdata(rd_d[2]),
        .avs_readdatavalid(rdv[2]), .err(er[2]));

    assign wr_m  = wr_q[sel];
    assign rd_m  = rd_d[sel];
    assign rdv_m = rdv[sel];
    assign err_m = er[sel];

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] model [3][1024];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rl_of(int s);
        return (s == 0) ? 1 : ((s == 1) ? 2 : 15);
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: every visible beat must match data and cycle
    always @(negedge clk) begin
        if (rdv_m) begin
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rdv: got data %h at cyc %0d, expected none",
                         rd_m, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (rd_m !== e.data || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL beat: got %h at cyc %0d expected %h at cyc %0d",
                             rd_m, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (wr_m) begin
            @(negedge clk);
            g++;
            if (g > 5000) begin
                $display("FAIL wait_ready: waitrequest stuck at 1, expected 0");
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_wait", int'(wr_m), 1);
        chk("rst_rdv", int'(rdv_m), 0);
        chk("rst_rdata", int'(rd_m), 0);
        chk("rst_err", int'(err_m), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_wait", int'(wr_m), 0);
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [10:0] bc,
                               input logic [15:0] base, input logic [15:0] step,
                               input logic [15:0] bubbles, input int rd_beat);
        int n = (bc == 0) ? 1 : int'(bc);
        wait_ready();
        for (int k = 0; k < n; k++) begin
            logic [15:0] d;
            if (k > 0 && k < 16 && bubbles[k % 16]) begin
                avs_write = 1'b0;
                avs_read  = 1'b0;
                @(negedge clk);
            end
            d = 16'(base + 16'(k) * step);
            avs_write      = 1'b1;
            avs_address    = addr;
            avs_burstcount = bc;
            avs_writedata  = d;
            avs_read       = (k == rd_beat);
            model[sel][(int'(addr[9:0]) + k) % 1024] = d;
            @(negedge clk);
        end
        avs_write = 1'b0;
        avs_read  = 1'b0;
    endtask

    task automatic issue_read(input logic [31:0] addr, input logic [10:0] bc,
                              input int npush, output int e0);
        int rl = rl_of(sel);
        wait_ready();
        avs_read       = 1'b1;
        avs_address    = addr;
        avs_burstcount = bc;
        e0 = cyc + 1;
        for (int k = 0; k < npush; k++) begin
            exp_t e;
            e.data = model[sel][(int'(addr[9:0]) + k) % 1024];
            e.cyc  = e0 + rl + k;
            sbq.push_back(e);
        end
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [10:0] bc);
        int n = (bc == 0) ? 1 : int'(bc);
        int e0;
        int cnt = 0;
        issue_read(addr, bc, n, e0);
        while (wr_m && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        chk("wait_span", cnt, rl_of(sel) + n - 1);
    endtask

    initial begin
        int e0;
        int g;

        // reset, single word
        do_reset();
        write_burst(32'h10, 11'd1, 16'hA5A5, 16'h0, 16'h0, -1);
        read_burst(32'h10, 11'd1);

        // burst of 8 with bubbles before beats 2 and 5
        write_burst(32'h100, 11'd8, 16'h0001, 16'h0001, 16'h0024, -1);
        read_burst(32'h100, 11'd8);

        // wrap-around; upper address bits ignored on the read
        write_burst(32'h3FE, 11'd4, 16'h1111, 16'h1111, 16'h0, -1);
        read_burst(32'hABCD_0000, 11'd2);
        chk("err_clean", int'(err_m), 0);

        // read+write together in IDLE
        write_burst(32'h20, 11'd1, 16'hBEEF, 16'h0, 16'h0, 0);
        chk("err_rw", int'(err_m), 1);
        repeat (3) @(negedge clk);
        chk("err_sticky", int'(err_m), 1);
        read_burst(32'h20, 11'd1);

        // read during write burst
        do_reset();
        write_burst(32'h40, 11'd4, 16'h4000, 16'h0001, 16'h0, 2);
        chk("err_wrburst", int'(err_m), 1);
        read_burst(32'h40, 11'd4);

        // burstcount 0 is one word
        write_burst(32'h50, 11'd0, 16'h5A5A, 16'h0, 16'h0, -1);
        write_burst(32'h60, 11'd1, 16'h6B6B, 16'h0, 16'h0, -1);
        read_burst(32'h50, 11'd0);
        read_burst(32'h60, 11'd1);

        // reset on the 3rd beat of a 16-beat read
        write_burst(32'h200, 11'd16, 16'hC000, 16'h0001, 16'h0, -1);
        issue_read(32'h200, 11'd16, 3, e0);
        g = 0;
        while (cyc < e0 + rl_of(sel) + 2 && g < 100) begin
            g++;
            @(negedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("abort_rdv", int'(rdv_m), 0);
        chk("abort_wait", int'(wr_m), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_post_wait", int'(wr_m), 0);
        chk("abort_sb_drained", sbq.size(), 0);
        read_burst(32'h200, 11'd16);

        // latency sweep with full 1024-word bursts
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            sel = s;
            @(negedge clk);
            write_burst(32'h0, 11'h400, 16'(16'h7000 + s * 16'h100), 16'h0003,
                        16'h0, -1);
            read_burst(32'h0, 11'h400);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
